mem_req_arbiter: RTL and testbench

//  Sits directly downstream of the cache miss port and the vector load/store unit. Arbitrates their request_t

---
 rtl/mem_req_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter of icache-miss and vector-unit requests onto one memory port, with read-credit limit and response routing by access_id; ARB_BURST_LOCK_EN adds burst locking.
// Latency: request to mem_req 1 cycle (registered), mem_rsp to ic_rsp/vu_rsp 1 cycle (registered).
// Backpressure: no grant while mem_req is held by !mem_ready_i or while read credits are exhausted.
package mem_req_pkg;
    localparam int ACCESS_ID_WIDTH = 8;

    typedef enum logic [1:0] {
        READ_REQ  = 2'd0,
        WRITE_REQ = 2'd1
    } access_type_t;

    typedef struct packed {
        logic                       vld;
        access_type_t               access_type;
        logic [ACCESS_ID_WIDTH-1:0] access_id;
        logic [31:0]                addr;
        logic [7:0]                 access_length;
        logic [31:0]                data;
    } request_t;
endpackage

module mem_req_arbiter
    import mem_req_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 64,
    parameter logic [1:0]  ICACHE_ID_TAG   = 2'b01
) (
    input  logic       clk,
    input  logic       reset,
    input  request_t   ic_req_i,
    output logic       ic_grant_o,
    output request_t   ic_rsp_o,
    input  request_t   vu_req_i,
    output logic       vu_grant_o,
    output request_t   vu_rsp_o,
    output request_t   mem_req_o,
    input  logic       mem_ready_i,
    input  request_t   mem_rsp_i,
    output logic [7:0] credits_free_o
);
    request_t   mem_req_q, mem_req_d;
    request_t   ic_rsp_q, ic_rsp_d;
    request_t   vu_rsp_q, vu_rsp_d;
    request_t   win_req;
    logic [7:0] outstanding_q, outstanding_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic       slot_free, can_issue, winner, win_vld, grant;
    logic       read_issue, pending_read, rsp_vld;
    logic [8:0] committed;
    logic [1:0] rsp_tag;
`ifdef ARB_BURST_LOCK_EN
    logic       lock_q, lock_d;
    logic       lock_port_q, lock_port_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
`endif

    assign slot_free    = !mem_req_q.vld || mem_ready_i;
    assign pending_read = mem_req_q.vld && (mem_req_q.access_type == READ_REQ);
    assign read_issue   = pending_read && mem_ready_i;
    assign rsp_vld      = mem_rsp_i.vld;
    assign rsp_tag      = mem_rsp_i.access_id[ACCESS_ID_WIDTH-1 -: 2];

    // A read parked in the output slot already owns a credit, so it is counted before it is accepted.
    assign committed = {1'b0, outstanding_q} + {8'd0, pending_read};
    assign can_issue = !reset && slot_free && (committed < 9'(MAX_OUTSTANDING));

    always_comb begin
        winner = rr_ptr_q;
        if (ic_req_i.vld && !vu_req_i.vld) begin
            winner = 1'b0;
        end else if (vu_req_i.vld && !ic_req_i.vld) begin
            winner = 1'b1;
        end
`ifdef ARB_BURST_LOCK_EN
        if (lock_q) begin
            winner = lock_port_q;
        end
`endif
    end

    assign win_req    = winner ? vu_req_i : ic_req_i;
    assign win_vld    = win_req.vld;
    assign grant      = can_issue && win_vld;
    assign ic_grant_o = grant && !winner;
    assign vu_grant_o = grant && winner;

    always_comb begin
        mem_req_d = mem_req_q;
        if (grant) begin
            mem_req_d = win_req;
        end else if (slot_free) begin
            mem_req_d = '0;
        end

        outstanding_d = outstanding_q;
        if (read_issue && !rsp_vld && outstanding_q != 8'hFF) begin
            outstanding_d = outstanding_q + 8'd1;
        end else if (rsp_vld && !read_issue && outstanding_q != 8'd0) begin
            outstanding_d = outstanding_q - 8'd1;
        end

        ic_rsp_d = '0;
        vu_rsp_d = '0;
        if (rsp_vld) begin
            if (rsp_tag == ICACHE_ID_TAG) begin
                ic_rsp_d = mem_rsp_i;
            end else begin
                vu_rsp_d = mem_rsp_i;
            end
        end

        rr_ptr_d = rr_ptr_q;
`ifdef ARB_BURST_LOCK_EN
        lock_d      = lock_q;
        lock_port_d = lock_port_q;
        burst_cnt_d = burst_cnt_q;
        if (grant) begin
            if (lock_q) begin
                burst_cnt_d = burst_cnt_q - 8'd1;
                if (burst_cnt_q == 8'd1) begin
                    lock_d   = 1'b0;
                    rr_ptr_d = ~lock_port_q;
                end
            end else if (win_req.access_length > 8'd1) begin
                // burst_cnt holds the grants still owed to the owner after this one
                lock_d      = 1'b1;
                lock_port_d = winner;
                burst_cnt_d = win_req.access_length - 8'd1;
            end else begin
                rr_ptr_d = ~winner;
            end
        end
`else
        if (grant) begin
            rr_ptr_d = ~winner;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_q     <= '0;
            ic_rsp_q      <= '0;
            vu_rsp_q      <= '0;
            outstanding_q <= 8'd0;
            rr_ptr_q      <= 1'b0;
`ifdef ARB_BURST_LOCK_EN
            lock_q        <= 1'b0;
            lock_port_q   <= 1'b0;
            burst_cnt_q   <= 8'd0;
`endif
        end else begin
            assert (!(rsp_vld && !read_issue && outstanding_q == 8'd0));
            mem_req_q     <= mem_req_d;
            ic_rsp_q      <= ic_rsp_d;
            vu_rsp_q      <= vu_rsp_d;
            outstanding_q <= outstanding_d;
            rr_ptr_q      <= rr_ptr_d;
`ifdef ARB_BURST_LOCK_EN
            lock_q        <= lock_d;
            lock_port_q   <= lock_port_d;
            burst_cnt_q   <= burst_cnt_d;
`endif
        end
    end

    assign mem_req_o      = mem_req_q;
    assign ic_rsp_o       = ic_rsp_q;
    assign vu_rsp_o       = vu_rsp_q;
    assign credits_free_o = 8'(MAX_OUTSTANDING) - outstanding_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter with a 4-credit instance.
module tb_mem_req_arbiter;
    import mem_req_pkg::*;

    localparam int MAXO = 4;

    logic       clk = 1'b0;
    logic       reset;
    request_t   ic_req, vu_req, mem_rsp;
    request_t   ic_rsp, vu_rsp, mem_req;
    logic       ic_grant, vu_grant, mem_ready;
    logic [7:0] credits_free;

    int n_cmp = 0;
    int n_err = 0;
    request_t req_q[$];
    request_t rsp_q[$];

    always #5 clk = ~clk;

    mem_req_arbiter #(
        .MAX_OUTSTANDING(MAXO),
        .ICACHE_ID_TAG  (2'b01)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ic_req_i      (ic_req),
        .ic_grant_o    (ic_grant),
        .ic_rsp_o      (ic_rsp),
        .vu_req_i      (vu_req),
        .vu_grant_o    (vu_grant),
        .vu_rsp_o      (vu_rsp),
        .mem_req_o     (mem_req),
        .mem_ready_i   (mem_ready),
        .mem_rsp_i     (mem_rsp),
        .credits_free_o(credits_free)
    );

    function automatic request_t mk(input access_type_t t, input logic [7:0] id,
                                    input logic [31:0] addr, input logic [7:0] len);
        request_t r;
        r               = '0;
        r.vld           = 1'b1;
        r.access_type   = t;
        r.access_id     = id;
        r.addr          = addr;
        r.access_length = len;
        r.data          = addr ^ 32'hA5A5_0000;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ic_req    = '0;
        vu_req    = '0;
        mem_rsp   = '0;
        mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        req_q.delete();
        rsp_q.delete();
    endtask

    task automatic test_reset();
        idle();
        reset  = 1'b1;
        ic_req = mk(READ_REQ, 8'h40, 32'h10, 8'd1);
        vu_req = mk(WRITE_REQ, 8'h05, 32'h20, 8'd1);
        cyc();
        cyc();
        n_cmp++;
        if ({ic_grant, vu_grant} !== 2'b00) begin
            n_err++; $display("FAIL reset_grants: got %b expected 00", {ic_grant, vu_grant});
        end
        n_cmp++;
        if (mem_req !== '0) begin
            n_err++; $display("FAIL reset_mem_req: got %h expected 0", mem_req);
        end
        n_cmp++;
        if (ic_rsp !== '0 || vu_rsp !== '0) begin
            n_err++; $display("FAIL reset_rsp: got ic %h vu %h expected 0", ic_rsp, vu_rsp);
        end
        n_cmp++;
        if (credits_free !== 8'(MAXO)) begin
            n_err++; $display("FAIL reset_credits: got %0d expected %0d", credits_free, MAXO);
        end
        idle();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_single_port();
        request_t r, exp;
        r = mk(READ_REQ, 8'd64, 32'h100, 8'd1);
        ic_req = r;
        #1;
        n_cmp++;
        if ({ic_grant, vu_grant} !== 2'b10) begin
            n_err++; $display("FAIL single_grant: got %b expected 10", {ic_grant, vu_grant});
        end
        req_q.push_back(r);
        cyc();
        ic_req = '0;
        exp = req_q.pop_front();
        n_cmp++;
        if (mem_req !== exp || mem_req.addr !== 32'h100) begin
            n_err++; $display("FAIL single_mem_req: got %h expected %h", mem_req, exp);
        end
        cyc();
        n_cmp++;
        if (credits_free !== 8'(MAXO - 1)) begin
            n_err++; $display("FAIL single_credits: got %0d expected %0d", credits_free, MAXO - 1);
        end
        r = mk(READ_REQ, 8'd64, 32'h100, 8'd1);
        mem_rsp = r;
        rsp_q.push_back(r);
        cyc();
        mem_rsp = '0;
        exp = rsp_q.pop_front();
        n_cmp++;
        if (ic_rsp !== exp || vu_rsp !== '0) begin
            n_err++; $display("FAIL single_rsp: got ic %h vu %h expected ic %h", ic_rsp, vu_rsp, exp);
        end
        cyc();
        n_cmp++;
        if (ic_rsp !== '0 || credits_free !== 8'(MAXO)) begin
            n_err++; $display("FAIL single_rsp_clear: got ic %h credits %0d expected 0 / %0d", ic_rsp, credits_free, MAXO);
        end
    endtask

    task automatic test_contention();
        request_t exp;
        int  ic_n, vu_n;
        logic exp_w;
        do_reset();
        ic_n  = 0;
        vu_n  = 0;
        exp_w = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ic_req = mk(WRITE_REQ, 8'h41, 32'h2000 + ic_n, 8'd1);
            vu_req = mk(WRITE_REQ, 8'h06, 32'h3000 + vu_n, 8'd1);
            #1;
            n_cmp++;
            if ({ic_grant, vu_grant} !== (exp_w ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL contention_grant[%0d]: got %b expected %b", i, {ic_grant, vu_grant}, exp_w ? 2'b01 : 2'b10);
            end
            if (exp_w) begin req_q.push_back(vu_req); vu_n++; end
            else       begin req_q.push_back(ic_req); ic_n++; end
            cyc();
            exp = req_q.pop_front();
            n_cmp++;
            if (mem_req !== exp) begin
                n_err++; $display("FAIL contention_mem_req[%0d]: got %h expected %h", i, mem_req, exp);
            end
            exp_w = ~exp_w;
        end
        idle();
        cyc();
    endtask

    task automatic test_credits();
        request_t exp;
        int n;
        do_reset();
        n = 0;
        for (int c = 0; c < 8; c++) begin
            ic_req = mk(READ_REQ, 8'h42, 32'h4000 + n, 8'd1);
            #1;
            n_cmp++;
            if (ic_grant !== (c < 4)) begin
                n_err++; $display("FAIL credits_grant[%0d]: got %b expected %b", c, ic_grant, c < 4);
            end
            if (c < 4) begin req_q.push_back(ic_req); n++; end
            cyc();
            if (c < 4) begin
                exp = req_q.pop_front();
                n_cmp++;
                if (mem_req !== exp) begin
                    n_err++; $display("FAIL credits_mem_req[%0d]: got %h expected %h", c, mem_req, exp);
                end
            end else begin
                n_cmp++;
                if (mem_req.vld !== 1'b0) begin
                    n_err++; $display("FAIL credits_stall[%0d]: got vld %b expected 0", c, mem_req.vld);
                end
            end
        end
        n_cmp++;
        if (credits_free !== 8'd0) begin
            n_err++; $display("FAIL credits_exhausted: got %0d expected 0", credits_free);
        end
        mem_rsp = mk(READ_REQ, 8'd5, 32'h0, 8'd1);
        #1;
        n_cmp++;
        if (ic_grant !== 1'b0) begin
            n_err++; $display("FAIL credits_same_cycle: got %b expected 0", ic_grant);
        end
        cyc();
        mem_rsp = '0;
        #1;
        n_cmp++;
        if (ic_grant !== 1'b1 || credits_free !== 8'd1) begin
            n_err++; $display("FAIL credits_regrant: got grant %b credits %0d expected 1 / 1", ic_grant, credits_free);
        end
        req_q.push_back(ic_req);
        cyc();
        ic_req = '0;
        exp = req_q.pop_front();
        n_cmp++;
        if (mem_req !== exp) begin
            n_err++; $display("FAIL credits_regrant_req: got %h expected %h", mem_req, exp);
        end
        for (int k = 0; k < 4; k++) begin
            mem_rsp = mk(READ_REQ, 8'd5, 32'h0, 8'd1);
            cyc();
        end
        mem_rsp = '0;
        cyc();
        n_cmp++;
        if (credits_free !== 8'(MAXO)) begin
            n_err++; $display("FAIL credits_drain: got %0d expected %0d", credits_free, MAXO);
        end
    endtask

    task automatic test_backpressure();
        request_t a, b, exp;
        do_reset();
        a = mk(WRITE_REQ, 8'h43, 32'h5000, 8'd1);
        b = mk(WRITE_REQ, 8'h43, 32'h5004, 8'd1);
        mem_ready = 1'b0;
        ic_req = a;
        #1;
        n_cmp++;
        if (ic_grant !== 1'b1) begin
            n_err++; $display("FAIL bp_first_grant: got %b expected 1", ic_grant);
        end
        req_q.push_back(a);
        cyc();
        ic_req = b;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (ic_grant !== 1'b0 || mem_req !== req_q[0]) begin
                n_err++; $display("FAIL bp_hold[%0d]: got grant %b req %h expected 0 / %h", i, ic_grant, mem_req, req_q[0]);
            end
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        exp = req_q.pop_front();
        n_cmp++;
        if (ic_grant !== 1'b1 || mem_req !== exp) begin
            n_err++; $display("FAIL bp_release: got grant %b req %h expected 1 / %h", ic_grant, mem_req, exp);
        end
        req_q.push_back(b);
        cyc();
        ic_req = '0;
        exp = req_q.pop_front();
        n_cmp++;
        if (mem_req !== exp) begin
            n_err++; $display("FAIL bp_next_req: got %h expected %h", mem_req, exp);
        end
        cyc();
    endtask

    task automatic test_routing();
        request_t   r, exp, exp_ic, exp_vu;
        logic [7:0] ids [4];
        bit         to_ic [4];
        ids   = '{8'd64, 8'd127, 8'd5, 8'd200};
        to_ic = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            ic_req = mk(READ_REQ, 8'h44, 32'h6000 + c, 8'd1);
            #1;
            req_q.push_back(ic_req);
            cyc();
            exp = req_q.pop_front();
            n_cmp++;
            if (mem_req !== exp) begin
                n_err++; $display("FAIL route_fill[%0d]: got %h expected %h", c, mem_req, exp);
            end
        end
        ic_req = '0;
        cyc();
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                ic_req = mk(READ_REQ, 8'h44, 32'h6100, 8'd1);
                #1;
                n_cmp++;
                if (ic_grant !== 1'b1) begin
                    n_err++; $display("FAIL route_grant: got %b expected 1", ic_grant);
                end
                req_q.push_back(ic_req);
                cyc();
                ic_req = '0;
                exp = req_q.pop_front();
                n_cmp++;
                if (mem_req !== exp) begin
                    n_err++; $display("FAIL route_grant_req: got %h expected %h", mem_req, exp);
                end
            end
            r = mk(READ_REQ, ids[k], 32'h7000 + k, 8'd1);
            mem_rsp = r;
            rsp_q.push_back(r);
            cyc();
            mem_rsp = '0;
            exp    = rsp_q.pop_front();
            exp_ic = to_ic[k] ? exp : '0;
            exp_vu = to_ic[k] ? '0 : exp;
            n_cmp++;
            if (ic_rsp !== exp_ic || vu_rsp !== exp_vu) begin
                n_err++; $display("FAIL route_rsp[id %0d]: got ic %h vu %h expected ic %h vu %h", ids[k], ic_rsp, vu_rsp, exp_ic, exp_vu);
            end
            if (k == 1) begin
                n_cmp++;
                if (credits_free !== 8'd1) begin
                    n_err++; $display("FAIL route_simultaneous: got credits %0d expected 1", credits_free);
                end
            end
        end
        mem_rsp = mk(READ_REQ, 8'd5, 32'h0, 8'd1);
        cyc();
        mem_rsp = '0;
        n_cmp++;
        if (credits_free !== 8'(MAXO)) begin
            n_err++; $display("FAIL route_drain: got %0d expected %0d", credits_free, MAXO);
        end
    endtask

    task automatic test_burst();
        request_t exp;
        int   ic_n, vu_n;
        logic exp_w;
        do_reset();
        ic_n = 0;
        vu_n = 0;
        for (int c = 0; c < 33; c++) begin
            ic_req = mk(WRITE_REQ, 8'h45, 32'h8000 + ic_n, 8'd32);
            vu_req = mk(WRITE_REQ, 8'h07, 32'h9000 + vu_n, 8'd1);
            #1;
`ifdef ARB_BURST_LOCK_EN
            exp_w = (c == 32);
`else
            exp_w = c[0];
`endif
            n_cmp++;
            if ({ic_grant, vu_grant} !== (exp_w ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL burst_grant[%0d]: got %b expected %b", c, {ic_grant, vu_grant}, exp_w ? 2'b01 : 2'b10);
            end
            if (exp_w) begin req_q.push_back(vu_req); vu_n++; end
            else       begin req_q.push_back(ic_req); ic_n++; end
            cyc();
            exp = req_q.pop_front();
            n_cmp++;
            if (mem_req !== exp) begin
                n_err++; $display("FAIL burst_mem_req[%0d]: got %h expected %h", c, mem_req, exp);
            end
        end
        idle();
        cyc();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_single_port();
        test_contention();
        test_credits();
        test_backpressure();
        test_routing();
        test_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
